// File: rtl/wb_sched_if.sv
// wb_sched_if -- bundle of all non-clock signals of the writeback scheduler.
//   ALU/jump request : alu_valid_i, alu_ready_o, alu_rd_i, alu_link_i, alu_data_i, pc_i
//   MEM request      : mem_valid_i, mem_ready_o, mem_rd_i, mem_data_i
//   RF / mux side    : rf_stall_i, rf_we_o, rf_waddr_o, mux_sel_o, mux_jump_o,
//                      mux_pc_o, mux_alu_o, mux_mem_o
//   Hazard query     : hz_rs1_i, hz_rs2_i, hz_rs1_o, hz_rs2_o
// Modport slave is the scheduler's view; master is the surrounding pipeline.
interface wb_sched_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      alu_valid_i;
   logic                      alu_ready_o;
   logic [REG_ADDR_WIDTH-1:0] alu_rd_i;
   logic                      alu_link_i;
   logic [DATA_WIDTH-1:0]     alu_data_i;
   logic [DATA_WIDTH-1:0]     pc_i;
   logic                      mem_valid_i;
   logic                      mem_ready_o;
   logic [REG_ADDR_WIDTH-1:0] mem_rd_i;
   logic [DATA_WIDTH-1:0]     mem_data_i;
   logic                      rf_stall_i;
   logic [1:0]                mux_sel_o;
   logic                      mux_jump_o;
   logic [DATA_WIDTH-1:0]     mux_pc_o;
   logic [DATA_WIDTH-1:0]     mux_alu_o;
   logic [DATA_WIDTH-1:0]     mux_mem_o;
   logic                      rf_we_o;
   logic [REG_ADDR_WIDTH-1:0] rf_waddr_o;
   logic [REG_ADDR_WIDTH-1:0] hz_rs1_i;
   logic [REG_ADDR_WIDTH-1:0] hz_rs2_i;
   logic                      hz_rs1_o;
   logic                      hz_rs2_o;

   modport slave (
      input  alu_valid_i, alu_rd_i, alu_link_i, alu_data_i, pc_i,
      input  mem_valid_i, mem_rd_i, mem_data_i, rf_stall_i, hz_rs1_i, hz_rs2_i,
      output alu_ready_o, mem_ready_o, mux_sel_o, mux_jump_o, mux_pc_o,
      output mux_alu_o, mux_mem_o, rf_we_o, rf_waddr_o, hz_rs1_o, hz_rs2_o
   );

   modport master (
      output alu_valid_i, alu_rd_i, alu_link_i, alu_data_i, pc_i,
      output mem_valid_i, mem_rd_i, mem_data_i, rf_stall_i, hz_rs1_i, hz_rs2_i,
      input  alu_ready_o, mem_ready_o, mux_sel_o, mux_jump_o, mux_pc_o,
      input  mux_alu_o, mux_mem_o, rf_we_o, rf_waddr_o, hz_rs1_o, hz_rs2_o
   );
endinterface

// File: rtl/wb_sched.sv
// wb_sched -- writeback scheduler for the register-file write port.
// Round-robin arbitration between the ALU/jump and load result paths into a
// small in-order FIFO; the FIFO head drives the writeback mux and RF write.
// Ports:
//   clk_i   clock (rising edge)
//   rst_ni  asynchronous active-low reset
//   bus     wb_sched_if.slave: request handshakes, mux/RF outputs, hazard query
// Build option: define WB_HAZARD_EN to build the pending-destination
// comparators; otherwise hz_rs1_o/hz_rs2_o are tied low.
// The interface widths must match DATA_WIDTH/REG_ADDR_WIDTH.
module wb_sched #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int DEPTH          = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   wb_sched_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef struct packed {
      logic [1:0]                sel;
      logic                      jump;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0]     data;
   } entry_t;

   entry_t          fifo_q [DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            prefer_mem_q, prefer_mem_d;

   entry_t head, new_entry;
   logic   head_valid, pop, space, grant_alu, grant_mem, push;

   always_comb begin
      head       = fifo_q[rptr_q];
      head_valid = (count_q != '0);
      pop        = head_valid && !bus.rf_stall_i;
      // a full FIFO still takes a request when the head leaves this cycle
      space      = (count_q < DEPTH_C) || pop;

      grant_alu = 1'b0;
      grant_mem = 1'b0;
      // rst_ni gating keeps ready low for the whole reset window
      if (rst_ni && space) begin
         if (bus.alu_valid_i && bus.mem_valid_i) begin
            if (prefer_mem_q) grant_mem = 1'b1;
            else              grant_alu = 1'b1;
         end else if (bus.alu_valid_i) begin
            grant_alu = 1'b1;
         end else if (bus.mem_valid_i) begin
            grant_mem = 1'b1;
         end
      end

      new_entry = '{sel: 2'b10, jump: 1'b0, rd: bus.mem_rd_i, data: bus.mem_data_i};
      if (grant_alu) begin
         if (bus.alu_link_i)
            new_entry = '{sel: 2'b00, jump: 1'b1, rd: bus.alu_rd_i, data: bus.pc_i};
         else
            new_entry = '{sel: 2'b01, jump: 1'b0, rd: bus.alu_rd_i, data: bus.alu_data_i};
      end

      // x0 writes are acknowledged but never occupy a slot
      push = (grant_alu || grant_mem) && (new_entry.rd != '0);

      wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);

      prefer_mem_d = prefer_mem_q;
      if (grant_alu)      prefer_mem_d = 1'b1;
      else if (grant_mem) prefer_mem_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         prefer_mem_q <= 1'b1;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         count_q      <= count_d;
         prefer_mem_q <= prefer_mem_d;
      end
   end

   // storage needs no reset: count_q alone defines which slots are live
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wptr_q] <= new_entry;
   end

   always_comb begin
      bus.alu_ready_o = grant_alu;
      bus.mem_ready_o = grant_mem;
      bus.rf_we_o     = 1'b0;
      bus.rf_waddr_o  = '0;
      bus.mux_sel_o   = 2'b11;
      bus.mux_jump_o  = 1'b0;
      bus.mux_pc_o    = '0;
      bus.mux_alu_o   = '0;
      bus.mux_mem_o   = '0;
      if (head_valid) begin
         bus.rf_we_o    = 1'b1;
         bus.rf_waddr_o = head.rd;
         bus.mux_sel_o  = head.sel;
         bus.mux_jump_o = head.jump;
         case (head.sel)
            2'b00:   bus.mux_pc_o  = head.data;
            2'b01:   bus.mux_alu_o = head.data;
            2'b10:   bus.mux_mem_o = head.data;
            default: ;
         endcase
      end
   end

`ifdef WB_HAZARD_EN
   logic [PW-1:0] hz_off;
   always_comb begin
      bus.hz_rs1_o = 1'b0;
      bus.hz_rs2_o = 1'b0;
      hz_off       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         // slot i is live when its distance from the read pointer is < count
         hz_off = PW'(i) - rptr_q;
         if (CW'(hz_off) < count_q) begin
            if (bus.hz_rs1_i != '0 && fifo_q[i].rd == bus.hz_rs1_i) bus.hz_rs1_o = 1'b1;
            if (bus.hz_rs2_i != '0 && fifo_q[i].rd == bus.hz_rs2_i) bus.hz_rs2_o = 1'b1;
         end
      end
   end
`else
   logic hz_unused;
   assign hz_unused    = ^{bus.hz_rs1_i, bus.hz_rs2_i};
   assign bus.hz_rs1_o = 1'b0;
   assign bus.hz_rs2_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_sched.sv
// tb_wb_sched -- randomized bench for wb_sched with a queue-based reference model.
module tb_wb_sched;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_sched_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

   wb_sched #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0]  sel;
      logic        jump;
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t q[$];
   bit   last_alu;   // last grant went to ALU -> MEM favoured next contest
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic hz_exp(input logic [4:0] rs);
`ifdef WB_HAZARD_EN
      if (rs == 5'd0) return 1'b0;
      foreach (q[i]) if (q[i].rd == rs) return 1'b1;
      return 1'b0;
`else
      return rs === 5'bx;
`endif
   endfunction

   task automatic drive_idle();
      bus.alu_valid_i = 0; bus.alu_rd_i = 0; bus.alu_link_i = 0;
      bus.alu_data_i = 0;  bus.pc_i = 0;
      bus.mem_valid_i = 0; bus.mem_rd_i = 0; bus.mem_data_i = 0;
      bus.rf_stall_i = 0;  bus.hz_rs1_i = 0; bus.hz_rs2_i = 0;
   endtask

   // one clock: drive at negedge, check combinational outputs, update model at posedge
   task automatic cyc(input logic av, input logic [4:0] ard, input logic alink,
                      input logic [31:0] adata, input logic [31:0] apc,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                      input logic stall, input logic [4:0] rs1, input logic [4:0] rs2);
      logic hv, pop, space, ga, gm;
      ent_t h, n;
      @(negedge clk);
      bus.alu_valid_i = av; bus.alu_rd_i = ard; bus.alu_link_i = alink;
      bus.alu_data_i = adata; bus.pc_i = apc;
      bus.mem_valid_i = mv; bus.mem_rd_i = mrd; bus.mem_data_i = mdata;
      bus.rf_stall_i = stall; bus.hz_rs1_i = rs1; bus.hz_rs2_i = rs2;
      #1;
      hv = (q.size() > 0);
      h  = '{sel: 2'b11, jump: 1'b0, rd: 5'd0, data: 32'd0};
      if (hv) h = q[0];
      pop   = hv && !stall;
      space = (q.size() < DEPTH) || pop;
      ga = space && av && (!mv || !last_alu);
      gm = space && mv && (!av || last_alu);
      check("alu_ready", bus.alu_ready_o, ga);
      check("mem_ready", bus.mem_ready_o, gm);
      check("rf_we", bus.rf_we_o, hv);
      check("mux_sel", bus.mux_sel_o, h.sel);
      if (hv) begin
         check("rf_waddr", bus.rf_waddr_o, h.rd);
         check("mux_jump", bus.mux_jump_o, h.jump);
      end
      check("mux_pc",  bus.mux_pc_o,  (hv && h.sel == 2'b00) ? h.data : 32'd0);
      check("mux_alu", bus.mux_alu_o, (hv && h.sel == 2'b01) ? h.data : 32'd0);
      check("mux_mem", bus.mux_mem_o, (hv && h.sel == 2'b10) ? h.data : 32'd0);
      check("hz_rs1", bus.hz_rs1_o, hz_exp(rs1));
      check("hz_rs2", bus.hz_rs2_o, hz_exp(rs2));
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (ga) n = alink ? '{2'b00, 1'b1, ard, apc} : '{2'b01, 1'b0, ard, adata};
      else    n = '{2'b10, 1'b0, mrd, mdata};
      if ((ga || gm) && n.rd != 5'd0) q.push_back(n);
      if (ga) last_alu = 1'b1;
      if (gm) last_alu = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"},  bus.rf_we_o, 1'b0);
      check({tag, "_sel"}, bus.mux_sel_o, 2'b11);
      check({tag, "_jmp"}, bus.mux_jump_o, 1'b0);
      check({tag, "_ar"},  bus.alu_ready_o, 1'b0);
      check({tag, "_mr"},  bus.mem_ready_o, 1'b0);
      check({tag, "_pc"},  bus.mux_pc_o, 32'd0);
      check({tag, "_alu"}, bus.mux_alu_o, 32'd0);
      check({tag, "_mem"}, bus.mux_mem_o, 32'd0);
   endtask

   initial begin
      logic av, mv, st, lk;
      logic [4:0] ard, mrd, r1, r2;
      drive_idle();
      bus.alu_valid_i = 1; bus.mem_valid_i = 1; bus.alu_rd_i = 3; bus.mem_rd_i = 4;
      last_alu = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("rst");
      drive_idle();
      rst_n = 1'b1;

      // single ALU write, visible one cycle later
      cyc(1, 5, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
      check("t1_alu", bus.mux_alu_o, 32'h1234);

      // simultaneous requests: MEM first after reset, then ALU link
      cyc(1, 1, 1, 32'hdead, 32'h8000_0010, 1, 2, 32'hcafe, 0, 0, 0);
      cyc(1, 1, 1, 32'hdead, 32'h8000_0010, 1, 2, 32'hcafe, 0, 0, 0);
      check("t2_head_rd2", bus.rf_waddr_o, 5'd2);
      idle(1);
      check("t2_pc", bus.mux_pc_o, 32'h8000_0010);
      idle(2);

      // stall fill: two accepted, third backpressured until release
      cyc(1, 10, 0, 32'h10, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 11, 0, 32'h11, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 12, 0, 32'h12, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 12, 0, 32'h12, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 12, 0, 32'h12, 0, 0, 0, 0, 0, 0, 0);
      idle(3);

      // x0 load: acknowledged, never written
      cyc(0, 0, 0, 0, 0, 1, 0, 32'h55, 0, 0, 0);
      idle(1);

      // hazard on a stalled pending rd=7
      cyc(1, 7, 0, 32'h77, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 7);
      idle(2);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         av = 1'($urandom_range(0, 1));
         mv = 1'($urandom_range(0, 1));
         lk = 1'($urandom_range(0, 1));
         st = ($urandom_range(0, 9) < 3);
         ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         r1 = 5'($urandom_range(0, 31));
         r2 = 5'($urandom_range(0, 31));
         if (q.size() > 0 && $urandom_range(0, 1) == 1) r1 = q[$urandom_range(0, q.size() - 1)].rd;
         cyc(av, ard, lk, $urandom, $urandom, mv, mrd, $urandom, st, r1, r2);
      end
      idle(3);

      // asynchronous reset with two entries stuck behind a stall
      cyc(1, 3, 0, 32'h33, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 4, 32'h44, 1, 0, 0);
      check("pre_rst_we", bus.rf_we_o, 1'b1);
      @(negedge clk);
      bus.alu_valid_i = 1; bus.alu_rd_i = 9; bus.mem_valid_i = 1; bus.mem_rd_i = 8;
      bus.rf_stall_i = 1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      q.delete();
      last_alu = 1'b1;
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
      idle(1);
      // MEM favoured again after reset
      cyc(1, 13, 0, 32'h13, 0, 1, 14, 32'h14, 0, 0, 0);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
